norm_stage: RTL
===============

Name: norm_stage

Overview:
- Per-lane normalization stage directly upstream of the pooling block in the norm/pool path.
- Takes one DESIGN_SIZE-lane row per cycle from the matmul output path and computes y = sat((x - mean) * inv_var >>> NORM_SHIFT) on every lane.
- Drives the pooling block's inp_data, in_data_available and validity_mask inputs.
- Pipelined with 2-cycle latency; counts rows to produce done_norm; registered bypass when disabled.

Parameters:
- DWIDTH, 16, lane width; signed two's complement.
- DESIGN_SIZE, 32, lanes per row and rows per tile.
- MASK_WIDTH, 32, validity mask width (one bit per lane).
- NORM_SHIFT, 8, fraction bits of inv_var (Q8.8 at defaults).

Ports:
- clk  in  1  clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 clears all state immediately.
- enable_norm  in  1  1 = normalize; 0 = bypass.
- mean  in  DWIDTH  signed scalar applied to all lanes; captured at tile start.
- inv_var  in  DWIDTH  signed Q(NORM_SHIFT) scale; captured at tile start.
- in_data_available  in  1  inp_data valid this cycle.
- inp_data  in  DESIGN_SIZE*DWIDTH  row; lane k = bits [k*DWIDTH +: DWIDTH].
- validity_mask  in  MASK_WIDTH  lane k is valid when bit k = 1.
- out_data  out  DESIGN_SIZE*DWIDTH  normalized row.
- out_data_available  out  1  out_data valid this cycle.
- out_validity_mask  out  MASK_WIDTH  mask aligned with out_data.
- done_norm  out  1  tile complete.

Behaviour:
- Reset (reset=0, async): out_data=0, out_data_available=0, out_validity_mask=0, done_norm=0, counters=0, state=IDLE, captured mean/inv_var=0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when enable_norm=1 and in_data_available=1. The same edge captures mean/inv_var into registers and accepts that row as row 0.
  - RUN -> DONE when out_count reaches DESIGN_SIZE.
  - any state -> IDLE when enable_norm=0. Both counters clear; done_norm_reg clears.
  - DONE holds until enable_norm=0.
- Input acceptance:
  - A row is accepted when state is IDLE or RUN, in_data_available=1, enable_norm=1 and in_count < DESIGN_SIZE.
  - Rows beyond DESIGN_SIZE, and any rows arriving in DONE, are dropped and produce no output.
- Bubbles: in_data_available may drop at any point in RUN. Each pipe stage carries its own valid bit; there is no stall and no backpressure.
- Stage 1 (register): per lane d = x - mean_reg, computed at DWIDTH+1 bits signed. The mask is registered alongside.
- Stage 2 (register):
  - p = d * inv_var_reg at 2*DWIDTH+1 bits signed; r = p >>> NORM_SHIFT (arithmetic shift, floor).
  - r saturates to [-2^(DWIDTH-1), 2^(DWIDTH-1)-1].
  - Lanes with a masked-off bit output 0.
  - out_data_available = stage-2 valid; out_count increments on each valid output.
- Latency: an accepted row at edge N appears on out_data after edge N+2.
- done_norm when enable_norm=1: registered. It rises the cycle the DESIGN_SIZE-th output is valid, is sticky in DONE, and clears on enable_norm=0.
- Bypass (enable_norm=0):
  - out_data, out_data_available and out_validity_mask are inp_data, in_data_available and validity_mask delayed by one register stage.
  - done_norm=1 combinationally.
  - The pipeline valid bits are flushed to 0.
- enable_norm falling mid-tile: in-flight rows are discarded with no partial output, and the FSM returns to IDLE. Re-enabling starts a fresh tile.
- mean/inv_var changing mid-tile: ignored; the captured values are used.
- Simultaneous last input and enable_norm fall: the disable wins and the row is discarded.

Decomposition:
- Shared package/header:
  - DWIDTH, DESIGN_SIZE, MASK_WIDTH and NORM_SHIFT defines.
  - FSM state encodings NORM_IDLE, NORM_RUN, NORM_DONE.
  - Saturation bounds.
- One sub-module, norm_lane: a single-lane 2-stage subtract/multiply/shift/saturate datapath with mask-zeroing.
  - Instantiated DESIGN_SIZE times by generate.
  - The top level holds the FSM, counters, valid pipe, parameter capture and bypass mux.

Test Plan:
- Basic: mean=10, inv_var=0x0100, all lanes x=30, mask all-ones, 32 back-to-back rows -> every lane 20, first output 2 cycles after the first input, done_norm rises with the 32nd output.
- Negative/floor: mean=10, inv_var=0x0080, x=-10 -> -10; x=-11 -> -11 (floor of -10.5); x=11 -> 0.
- Saturation: mean=-32768, inv_var=0x0200, x=32767 -> 32767; mean=32767, x=-32768 -> -32768.
- Mask and bubbles: validity_mask=0x0000FFFF; rows driven every other cycle -> lanes 16..31 are 0; outputs keep the gaps; done_norm only after 32 valid outputs; a 33rd input row is dropped.
- Bypass/disable: enable_norm=0 -> out_data equals inp_data one cycle later and done_norm=1. Drop enable_norm after 5 rows, then re-enable -> count restarts and 32 new rows are needed for done_norm.
- Async reset: pull reset low mid-tile between clock edges -> all outputs 0 immediately, state IDLE; after release the next tile behaves normally.

Source files
------------

// File: rtl/norm_stage_pkg.sv
// Shared definitions for the normalization stage ahead of the pooling block.
// Holds lane/row geometry, fixed-point scaling, saturation bounds and the
// tile-control state encoding used by norm_stage and norm_lane.
package norm_stage_pkg;

    localparam int unsigned DWIDTH      = 16;  // lane width, signed
    localparam int unsigned DESIGN_SIZE = 32;  // lanes per row, rows per tile
    localparam int unsigned MASK_WIDTH  = 32;  // one validity bit per lane
    localparam int unsigned NORM_SHIFT  = 8;   // fraction bits of inv_var

    localparam int unsigned ROW_W  = DESIGN_SIZE * DWIDTH;
    localparam int unsigned CNT_W  = $clog2(DESIGN_SIZE + 1);
    localparam int unsigned DIFF_W = DWIDTH + 1;      // x - mean never overflows
    localparam int unsigned PROD_W = 2 * DWIDTH + 1;  // (x - mean) * inv_var

    localparam logic signed [DWIDTH-1:0] SAT_MAX = {1'b0, {(DWIDTH-1){1'b1}}};
    localparam logic signed [DWIDTH-1:0] SAT_MIN = {1'b1, {(DWIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        NORM_IDLE = 2'd0,
        NORM_RUN  = 2'd1,
        NORM_DONE = 2'd2
    } norm_state_e;

endpackage

// File: rtl/norm_lane.sv
// Single-lane normalization datapath.
//   stage 1: diff = x - mean (DWIDTH+1 bits)
//   stage 2: y = sat((diff * inv_var) >>> NORM_SHIFT), zero when lane masked,
//            or the raw bypass sample bx when bypass is set.
// Ports: clk, reset (async active-low), bypass, mask_bit (stage-2 aligned),
//        x (registered row lane), bx (raw input lane), mean, inv_var, y.
module norm_lane
    import norm_stage_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              bypass,
    input  logic              mask_bit,
    input  logic [DWIDTH-1:0] x,
    input  logic [DWIDTH-1:0] bx,
    input  logic [DWIDTH-1:0] mean,
    input  logic [DWIDTH-1:0] inv_var,
    output logic [DWIDTH-1:0] y
);

    logic signed [DIFF_W-1:0] diff_d, diff_q;
    logic signed [PROD_W-1:0] prod_c, shr_c;
    logic        [DWIDTH-1:0] y_d, y_q;

    // Stage 1: widened subtract
    always_comb begin
        diff_d = DIFF_W'($signed(x)) - DIFF_W'($signed(mean));
    end

    // Stage 2: scale, floor shift, saturate, mask / bypass select
    always_comb begin
        prod_c = PROD_W'(diff_q) * PROD_W'($signed(inv_var));
        shr_c  = prod_c >>> NORM_SHIFT;
        y_d    = '0;
        if (bypass) begin
            y_d = bx;
        end else if (!mask_bit) begin
            y_d = '0;
        end else if (shr_c > PROD_W'(SAT_MAX)) begin
            y_d = SAT_MAX;
        end else if (shr_c < PROD_W'(SAT_MIN)) begin
            y_d = SAT_MIN;
        end else begin
            y_d = shr_c[DWIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            diff_q <= '0;
            y_q    <= '0;
        end else begin
            diff_q <= diff_d;
            y_q    <= y_d;
        end
    end

    assign y = y_q;

endmodule

// File: rtl/norm_stage.sv
// Per-lane normalization stage feeding the pooling block.
// Accepts one DESIGN_SIZE-lane row per cycle, outputs
// sat((x - mean) * inv_var >>> NORM_SHIFT) two edges after acceptance,
// counts a tile of DESIGN_SIZE rows and raises done_norm with the last output.
// enable_norm=0 gives a one-register bypass and flushes in-flight rows.
// Ports: clk, reset (async active-low), enable_norm, mean, inv_var,
//        in_data_available, inp_data, validity_mask,
//        out_data, out_data_available, out_validity_mask, done_norm.
module norm_stage
    import norm_stage_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable_norm,
    input  logic [DWIDTH-1:0]     mean,
    input  logic [DWIDTH-1:0]     inv_var,
    input  logic                  in_data_available,
    input  logic [ROW_W-1:0]      inp_data,
    input  logic [MASK_WIDTH-1:0] validity_mask,
    output logic [ROW_W-1:0]      out_data,
    output logic                  out_data_available,
    output logic [MASK_WIDTH-1:0] out_validity_mask,
    output logic                  done_norm
);

    norm_state_e           state_d, state_q;
    logic [CNT_W-1:0]      in_count_d, in_count_q;
    logic [CNT_W-1:0]      out_count_d, out_count_q;
    logic                  done_d, done_q;
    logic [DWIDTH-1:0]     mean_d, mean_q;
    logic [DWIDTH-1:0]     inv_var_d, inv_var_q;
    logic [ROW_W-1:0]      row_d, row_q;
    logic [MASK_WIDTH-1:0] mask0_d, mask0_q;
    logic [MASK_WIDTH-1:0] mask1_d, mask1_q;
    logic                  v0_d, v0_q;
    logic                  v1_d, v1_q;
    logic                  avail_d, avail_q;
    logic [MASK_WIDTH-1:0] omask_d, omask_q;
    logic                  accept_c;
    logic                  v2_c;
    logic                  bypass_c;

    // Control: acceptance, valid pipe, counters, capture, FSM, output mux
    always_comb begin
        bypass_c = !enable_norm;
        accept_c = enable_norm && in_data_available && (state_q != NORM_DONE)
                   && (in_count_q < CNT_W'(DESIGN_SIZE));
        // Valid bits die immediately when the stage is disabled
        v0_d     = accept_c;
        v1_d     = enable_norm && v0_q;
        v2_c     = enable_norm && v1_q;

        row_d    = inp_data;
        mask0_d  = validity_mask;
        mask1_d  = mask0_q;

        in_count_d  = enable_norm ? (in_count_q + CNT_W'(accept_c)) : '0;
        out_count_d = enable_norm ? (out_count_q + CNT_W'(v2_c)) : '0;
        done_d      = enable_norm && (done_q || (out_count_d == CNT_W'(DESIGN_SIZE)));

        // Scale factors are latched only by the row that opens a tile
        mean_d    = mean_q;
        inv_var_d = inv_var_q;
        if (accept_c && (state_q == NORM_IDLE)) begin
            mean_d    = mean;
            inv_var_d = inv_var;
        end

        state_d = state_q;
        if (!enable_norm) begin
            state_d = NORM_IDLE;
        end else begin
            case (state_q)
                NORM_IDLE: if (accept_c) state_d = NORM_RUN;
                NORM_RUN:  if (out_count_d == CNT_W'(DESIGN_SIZE)) state_d = NORM_DONE;
                NORM_DONE: state_d = NORM_DONE;
                default:   state_d = NORM_IDLE;
            endcase
        end

        avail_d = enable_norm ? v2_c : in_data_available;
        omask_d = enable_norm ? mask1_q : validity_mask;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= NORM_IDLE;
            in_count_q  <= '0;
            out_count_q <= '0;
            done_q      <= 1'b0;
            mean_q      <= '0;
            inv_var_q   <= '0;
            row_q       <= '0;
            mask0_q     <= '0;
            mask1_q     <= '0;
            v0_q        <= 1'b0;
            v1_q        <= 1'b0;
            avail_q     <= 1'b0;
            omask_q     <= '0;
        end else begin
            state_q     <= state_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            done_q      <= done_d;
            mean_q      <= mean_d;
            inv_var_q   <= inv_var_d;
            row_q       <= row_d;
            mask0_q     <= mask0_d;
            mask1_q     <= mask1_d;
            v0_q        <= v0_d;
            v1_q        <= v1_d;
            avail_q     <= avail_d;
            omask_q     <= omask_d;
        end
    end

    // Lane datapaths; stage-2 register doubles as the bypass register
    for (genvar k = 0; k < DESIGN_SIZE; k++) begin : g_lane
        norm_lane u_lane (
            .clk      (clk),
            .reset    (reset),
            .bypass   (bypass_c),
            .mask_bit (mask1_q[k]),
            .x        (row_q[k*DWIDTH +: DWIDTH]),
            .bx       (inp_data[k*DWIDTH +: DWIDTH]),
            .mean     (mean_q),
            .inv_var  (inv_var_q),
            .y        (out_data[k*DWIDTH +: DWIDTH])
        );
    end

    assign out_data_available = avail_q;
    assign out_validity_mask  = omask_q;
    // Disabled stage always reports completion
    assign done_norm          = enable_norm ? done_q : 1'b1;

endmodule
